vga_test_pattern_gen: RTL and testbench

Parametrised, registered VGA test-pattern source with four runtime-selectable modes: colour bars, a bouncing "no signal" box, a scrolling checkerboard and a grey ramp. It sits between the vga_controller (which supplies x, y, video_on and p_tick) and the RGB output pins. Animation state (box position and direction, scroll offset) advances once per frame. Mode changes take effect only at frame boundaries, so no frame is ever torn.

---
 rtl/vga_tpg_pkg.sv | 25 ++
 rtl/tpg_bounce_axis.sv | 40 ++++
 rtl/vga_test_pattern_gen.sv | 100 ++++++++++
 tb/tb_vga_test_pattern_gen.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/vga_tpg_pkg.sv
// Shared colours, bar tables and mode encoding for the VGA test-pattern generator.
package vga_tpg_pkg;

  localparam logic [11:0] RED    = 12'h00F;
  localparam logic [11:0] GREEN  = 12'h0F0;
  localparam logic [11:0] BLUE   = 12'hF00;
  localparam logic [11:0] YELLOW = 12'h0FF;
  localparam logic [11:0] AQUA   = 12'hFF0;
  localparam logic [11:0] VIOLET = 12'hF0F;
  localparam logic [11:0] WHITE  = 12'hFFF;
  localparam logic [11:0] BLACK  = 12'h000;
  localparam logic [11:0] GRAY   = 12'hAAA;

  // Entry [0] is the leftmost bar (last element of the concatenation).
  localparam logic [6:0][11:0] UPPER_BARS = {BLUE, RED, VIOLET, GREEN, AQUA, YELLOW, WHITE};
  localparam logic [6:0][11:0] LOWER_BARS = {WHITE, BLACK, AQUA, GRAY, VIOLET, BLACK, BLUE};

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_BOX   = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_RAMP  = 2'd3
  } tpg_mode_e;

endpackage

// File: rtl/tpg_bounce_axis.sv
// One axis of the bouncing box: position plus direction, reversing at either edge.
module tpg_bounce_axis #(
  parameter int LIMIT    = 640,
  parameter int BOX_SIZE = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       step,
  output logic [9:0] pos,
  output logic       dir,
  output logic       bounce
);

  localparam logic [9:0] POS_MAX = 10'(LIMIT - BOX_SIZE);

  logic at_max, at_min;

  // dir 0 = increasing (right/down), 1 = decreasing (left/up)
  assign at_max = !dir && (pos == POS_MAX);
  assign at_min =  dir && (pos == 10'd0);
  assign bounce = step && (at_max || at_min);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos <= '0;
      dir <= 1'b0;
    end else if (step) begin
      if (at_max) begin
        dir <= 1'b1;
        pos <= pos - 10'd1;
      end else if (at_min) begin
        dir <= 1'b0;
        pos <= pos + 10'd1;
      end else begin
        pos <= dir ? pos - 10'd1 : pos + 10'd1;
      end
    end
  end

endmodule

// File: rtl/vga_test_pattern_gen.sv
// Registered VGA test-pattern source: bars, bouncing box, scrolling checker, grey ramp.
// Define VGA_TPG_BORDER_EN to overlay a 1-pixel white border on every mode.
module vga_test_pattern_gen
  import vga_tpg_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int NUM_BARS    = 7,
  parameter int LOWER_Y     = 412,
  parameter int BOX_SIZE    = 64,
  parameter int CHECK_SHIFT = 5,
  parameter int GRAD_SHIFT  = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic [1:0]  mode,
  output logic [11:0] rgb,
  output logic        video_on_q,
  output logic [1:0]  mode_active,
  output logic [9:0]  frame_cnt
);

  localparam int BAR_W = H_ACTIVE / NUM_BARS;

  logic        frame_tick;
  logic [9:0]  box_x, box_y;
  logic        dir_x, dir_y, bounce_x, bounce_y;
  logic [2:0]  color_idx;
  logic [11:0] pix;

  assign frame_tick = p_tick && (x == 10'd0) && (y == 10'd0);

  tpg_bounce_axis #(.LIMIT(H_ACTIVE), .BOX_SIZE(BOX_SIZE)) u_axis_x (
    .clk(clk), .reset_n(reset_n), .step(frame_tick),
    .pos(box_x), .dir(dir_x), .bounce(bounce_x)
  );

  tpg_bounce_axis #(.LIMIT(V_ACTIVE), .BOX_SIZE(BOX_SIZE)) u_axis_y (
    .clk(clk), .reset_n(reset_n), .step(frame_tick),
    .pos(box_y), .dir(dir_y), .bounce(bounce_y)
  );

  always_comb begin
    logic [9:0]  bar_q;
    logic [2:0]  bar_i;
    logic [9:0]  cx, gq;
    logic [3:0]  lvl;
    logic [10:0] x_e, y_e, bx_e, by_e;
    logic        in_box;
    pix   = BLACK;
    bar_q = x / 10'(BAR_W);
    if (bar_q > 10'(NUM_BARS - 1)) bar_q = 10'(NUM_BARS - 1);
    bar_i = 3'(bar_q % 10'd7);
    // checkerboard scrolls by folding the frame count into x; wraps at 10 bits
    cx    = x + frame_cnt;
    gq    = x >> GRAD_SHIFT;
    lvl   = (gq > 10'd15) ? 4'hF : gq[3:0];
    x_e   = {1'b0, x};
    y_e   = {1'b0, y};
    bx_e  = {1'b0, box_x};
    by_e  = {1'b0, box_y};
    in_box = (x_e >= bx_e) && (x_e < bx_e + 11'(BOX_SIZE)) &&
             (y_e >= by_e) && (y_e < by_e + 11'(BOX_SIZE));
    case (tpg_mode_e'(mode_active))
      MODE_BARS:  pix = (y < 10'(LOWER_Y)) ? UPPER_BARS[bar_i] : LOWER_BARS[bar_i];
      MODE_BOX:   pix = in_box ? UPPER_BARS[color_idx] : BLACK;
      MODE_CHECK: pix = (cx[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? WHITE : BLACK;
      default:    pix = {lvl, lvl, lvl};
    endcase
`ifdef VGA_TPG_BORDER_EN
    if (x == 10'd0 || x == 10'(H_ACTIVE - 1) || y == 10'd0 || y == 10'(V_ACTIVE - 1))
      pix = WHITE;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb         <= BLACK;
      video_on_q  <= 1'b0;
      mode_active <= 2'd0;
      frame_cnt   <= '0;
      color_idx   <= '0;
    end else if (p_tick) begin
      rgb        <= video_on ? pix : BLACK;
      video_on_q <= video_on;
      if (frame_tick) begin
        mode_active <= mode;
        frame_cnt   <= frame_cnt + 10'd1;
        // a corner hit bounces both axes but advances the colour once
        if (bounce_x || bounce_y)
          color_idx <= (color_idx == 3'd6) ? 3'd0 : color_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_test_pattern_gen.sv
// Directed scoreboard bench: default-size DUT plus a square-screen DUT for the corner bounce.
module tb_vga_test_pattern_gen;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] rgb1, rgb2;
  logic        voq1, voq2;
  logic [1:0]  ma1, ma2;
  logic [9:0]  fc1, fc2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    int          dut;
    logic [11:0] rgb;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  vga_test_pattern_gen dut1 (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .mode(mode), .rgb(rgb1), .video_on_q(voq1),
    .mode_active(ma1), .frame_cnt(fc1)
  );

  vga_test_pattern_gen #(.H_ACTIVE(160), .V_ACTIVE(160), .BOX_SIZE(32)) dut2 (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .mode(mode), .rgb(rgb2), .video_on_q(voq2),
    .mode_active(ma2), .frame_cnt(fc2)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] ex);
    checks++;
    assert (obs === ex) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, ex);
    end
  endtask

  // one pixel on p_tick; expectation queued at drive time, popped after the edge
  task automatic px(input logic [9:0] xi, input logic [9:0] yi, input logic von,
                    input logic [11:0] e, input int d, input string tag);
    exp_t it;
    x = xi; y = yi; video_on = von; p_tick = 1'b1;
    sb.push_back('{tag: tag, dut: d, rgb: e});
    @(posedge clk); #1;
    p_tick = 1'b0;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s: got empty scoreboard expected entry", tag);
    end else begin
      it = sb.pop_front();
      chk(it.tag, (it.dut == 2) ? rgb2 : rgb1, it.rgb);
    end
  endtask

  task automatic ft(input int n);
    for (int i = 0; i < n; i++) begin
      x = '0; y = '0; video_on = 1'b1; p_tick = 1'b1;
      @(posedge clk); #1;
      p_tick = 1'b0;
    end
  endtask

  initial begin
    #3;
    chk("rst_rgb", rgb1, 12'h000);
    chk("rst_voq", 12'(voq1), 12'h0);
    chk("rst_mode", 12'(ma1), 12'h0);
    chk("rst_fc", 12'(fc1), 12'h0);
    #9 reset_n = 1'b1;

    // colour bars
    px(10'd0,   10'd0,   1'b1, 12'hFFF, 1, "bar_0_0");
    px(10'd91,  10'd0,   1'b1, 12'h0FF, 1, "bar_91_0");
    px(10'd639, 10'd0,   1'b1, 12'hF00, 1, "bar_639_0");
    px(10'd100, 10'd412, 1'b1, 12'h000, 1, "bar_100_412");
    chk("bar_voq", 12'(voq1), 12'h1);
    chk("bar_fc", 12'(fc1), 12'd1);

    // no p_tick: output holds
    x = 10'd0; y = 10'd5; video_on = 1'b1; p_tick = 1'b0;
    @(posedge clk); #1;
    chk("hold_rgb", rgb1, 12'h000);

    // mid-frame mode request waits for the frame tick
    mode = 2'd2;
    px(10'd300, 10'd200, 1'b1, 12'h0F0, 1, "sw_mid_bars");
    chk("sw_mode_hold", 12'(ma1), 12'd0);
    ft(1);
    chk("sw_mode_latch", 12'(ma1), 12'd2);
    ft(3);
    chk("chk_fc5", 12'(fc1), 12'd5);
    px(10'd27, 10'd0,  1'b1, 12'hFFF, 1, "chk_27_0");
    px(10'd26, 10'd0,  1'b1, 12'h000, 1, "chk_26_0");
    px(10'd27, 10'd32, 1'b1, 12'h000, 1, "chk_27_32");

    // grey ramp
    mode = 2'd3;
    ft(1);
    px(10'd64,  10'd10, 1'b1, 12'h222, 1, "ramp_64");
    px(10'd479, 10'd10, 1'b1, 12'hEEE, 1, "ramp_479");
    px(10'd600, 10'd10, 1'b1, 12'hFFF, 1, "ramp_600");
    px(10'd64,  10'd10, 1'b0, 12'h000, 1, "ramp_blank");
    chk("ramp_blank_voq", 12'(voq1), 12'h0);
    px(10'd600, 10'd10, 1'b1, 12'hFFF, 1, "ramp_600b");

    // asynchronous reset mid-line
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rgb", rgb1, 12'h000);
    chk("arst_fc", 12'(fc1), 12'h0);
    chk("arst_mode", 12'(ma1), 12'h0);
    #3 reset_n = 1'b1;

    // bouncing box from (0,0)
    mode = 2'd1;
    for (int t = 1; t <= 577; t++) begin
      ft(1);
      if (t == 1) begin
        chk("box_mode", 12'(ma1), 12'd1);
        px(10'd1, 10'd1, 1'b1, 12'hFFF, 1, "box_start_in");
        px(10'd0, 10'd1, 1'b1, 12'h000, 1, "box_start_out");
      end
      if (t == 128) px(10'd128, 10'd128, 1'b1, 12'hFFF, 2, "corner_pre");
      if (t == 129) begin
        px(10'd127, 10'd127, 1'b1, 12'h0FF, 2, "corner_once");
        px(10'd126, 10'd127, 1'b1, 12'h000, 2, "corner_out");
      end
      if (t == 576) begin
        px(10'd576, 10'd256, 1'b1, 12'h0FF, 1, "box_x576_in");
        px(10'd575, 10'd256, 1'b1, 12'h000, 1, "box_x576_out");
      end
      if (t == 577) begin
        px(10'd575, 10'd255, 1'b1, 12'hFF0, 1, "box_x575_in");
        px(10'd639, 10'd255, 1'b1, 12'h000, 1, "box_x575_out");
      end
    end
    chk("box_fc", 12'(fc1), 12'd577);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
